// File: rtl/tier2_stream_packer.sv
// Tier-2 output packer: 16-bit codestream words in, big-endian OUT_BYTES-wide words with byte enables out, byte budget and EOC.
// Latency: a full word appears on the cycle after its last lane is filled; the EOC partial word appears 1-2 cycles after EOC.
// Backpressure: in_ready is high only in PACK and DRAIN. One word is accepted per cycle. The output side is never stalled.
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   start               : begins an image (sampled in IDLE/DONE only)
//   target_byte_number  : byte budget incl. EOC, latched at start (0 = unlimited)
//   in_data/in_two/in_last/in_valid/in_ready : input word stream
//   output_to_fpga/write_en/output_address   : packed output word, byte enables, word address
//   bytes_written       : bytes emitted for the current image (saturating)
//   one_image_over      : 1-cycle pulse on entry to DONE
module tier2_stream_packer #(
  parameter int                    OUT_BYTES  = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    CNT_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    target_byte_number,
  input  logic [15:0]             in_data,
  input  logic                    in_two,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*OUT_BYTES-1:0]  output_to_fpga,
  output logic [OUT_BYTES-1:0]    write_en,
  output logic [ADDR_WIDTH-1:0]   output_address,
  output logic [CNT_WIDTH-1:0]    bytes_written,
  output logic                    one_image_over
);

  localparam int PW = $clog2(OUT_BYTES);
  localparam int DW = 8 * OUT_BYTES;
  localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PACK,
    S_EOC,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DW-1:0]         r_buf;
  logic [PW-1:0]         r_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_target;
  logic                  r_last_seen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]         r_out_dat;
  logic [OUT_BYTES-1:0]  r_we;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [CNT_WIDTH-1:0]  r_bw;
  logic                  r_over;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_start;
  logic [1:0]            w_n;
  logic [1:0]            w_a;
  logic [CNT_WIDTH-1:0]  w_rem;
  logic                  w_trunc;
  logic                  w_exhaust;

  logic [1:0]            w_ins_n;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [PW:0]           w_ptr_ext;
  logic [PW:0]           w_ptr_p1;
  logic [PW:0]           w_ptr_sum;
  logic                  w_full;
  logic [2*DW-1:0]       w_ext;
  logic [DW-1:0]         w_buf_nxt;

  logic                  w_wr;
  logic [DW-1:0]         w_wr_dat;
  logic [OUT_BYTES-1:0]  w_wr_we;
  logic [PW:0]           w_wr_bytes;
  logic [CNT_WIDTH:0]    w_bw_sum;

  assign w_accept = in_valid && w_in_ready;
  assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_n      = in_two ? 2'd2 : 2'd1;

  // Data bytes still allowed before the two EOC bytes. Budgets of 1 or 2
  // leave no room for data at all.
  always_comb begin
    w_rem = '0;
    if (r_target > TWO) begin
      w_rem = r_target - TWO - r_cnt;
    end
  end

  always_comb begin
    w_a = w_n;
    if (r_target != '0 && CNT_WIDTH'(w_n) > w_rem) begin
      w_a = w_rem[1:0];
    end
  end

  assign w_trunc   = (w_a != w_n);
  assign w_exhaust = (r_target != '0) && (CNT_WIDTH'(w_a) == w_rem);

  // FSM: next state and in_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_PACK;
        end
      end
      S_PACK: begin
        w_in_ready = 1'b1;
        if (in_valid && (w_trunc || w_exhaust || in_last)) begin
          w_state_nxt = S_EOC;
        end
      end
      S_EOC: begin
        w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_state_nxt = r_last_seen ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        w_in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready = w_in_ready;

  // Bytes entering the packing path this cycle: allowed data bytes in PACK,
  // or the EOC marker in EOC.
  always_comb begin
    w_ins_n = 2'd0;
    w_b0    = in_data[15:8];
    w_b1    = in_data[7:0];
    if (r_state == S_PACK && w_accept) begin
      w_ins_n = w_a;
    end else if (r_state == S_EOC) begin
      w_ins_n = 2'd2;
      w_b0    = 8'hFF;
      w_b1    = 8'hD9;
    end
  end

  assign w_ptr_ext = {1'b0, r_ptr};
  assign w_ptr_p1  = w_ptr_ext + (PW+1)'(1);
  assign w_ptr_sum = w_ptr_ext + (PW+1)'(w_ins_n);
  assign w_full    = w_ptr_sum[PW];

  // Two words' worth of lanes: the upper half is the word being built, the
  // lower half catches a byte that spills past lane OUT_BYTES-1 and becomes
  // lane 0 of the following word with the same bit layout.
  always_comb begin
    w_ext = {r_buf, {DW{1'b0}}};
    for (int k = 0; k < 2*OUT_BYTES; k++) begin
      if ((w_ins_n != 2'd0) && (k[PW:0] == w_ptr_ext)) begin
        w_ext[8*(2*OUT_BYTES-k)-1 -: 8] = w_b0;
      end
      if ((w_ins_n == 2'd2) && (k[PW:0] == w_ptr_p1)) begin
        w_ext[8*(2*OUT_BYTES-k)-1 -: 8] = w_b1;
      end
    end
  end

  assign w_buf_nxt = w_full ? w_ext[DW-1:0] : w_ext[2*DW-1:DW];

  // Write selection: a completed word, or the partial word in FLUSH. Lane k
  // maps to enable bit OUT_BYTES-1-k, so lanes 0..ptr-1 are the top ptr bits.
  always_comb begin
    w_wr       = 1'b0;
    w_wr_dat   = '0;
    w_wr_we    = '0;
    w_wr_bytes = '0;
    if (w_full) begin
      w_wr       = 1'b1;
      w_wr_dat   = w_ext[2*DW-1:DW];
      w_wr_we    = '1;
      w_wr_bytes = (PW+1)'(OUT_BYTES);
    end else if (r_state == S_FLUSH && r_ptr != '0) begin
      w_wr       = 1'b1;
      w_wr_dat   = r_buf;
      w_wr_we    = ~({OUT_BYTES{1'b1}} >> r_ptr);
      w_wr_bytes = w_ptr_ext;
    end
  end

  assign w_bw_sum = {1'b0, r_bw} + (CNT_WIDTH+1)'(w_wr_bytes);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_target    <= '0;
      r_last_seen <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_out_dat   <= '0;
      r_we        <= '0;
      r_out_addr  <= BASE_ADDR;
      r_bw        <= '0;
      r_over      <= 1'b0;
    end else begin
      r_over <= (w_state_nxt == S_DONE) && (r_state != S_DONE);

      if (w_wr) begin
        r_out_dat  <= w_wr_dat;
        r_we       <= w_wr_we;
        r_out_addr <= r_addr;
        r_addr     <= r_addr + ADDR_WIDTH'(1);
        r_bw       <= w_bw_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_bw_sum[CNT_WIDTH-1:0];
      end else begin
        r_out_dat <= '0;
        r_we      <= '0;
      end

      if (r_state == S_PACK || r_state == S_EOC) begin
        r_buf <= w_buf_nxt;
        r_ptr <= w_ptr_sum[PW-1:0];
      end else if (r_state == S_FLUSH) begin
        r_buf <= '0;
        r_ptr <= '0;
      end

      if (r_state == S_PACK && w_accept) begin
        r_cnt <= r_cnt + CNT_WIDTH'(w_a);
        if (in_last) begin
          r_last_seen <= 1'b1;
        end
      end

      if (w_start) begin
        r_target    <= target_byte_number;
        r_cnt       <= '0;
        r_ptr       <= '0;
        r_buf       <= '0;
        r_addr      <= BASE_ADDR;
        r_last_seen <= 1'b0;
        r_bw        <= '0;
      end
    end
  end

  assign output_to_fpga = r_out_dat;
  assign write_en       = r_we;
  assign output_address = r_out_addr;
  assign bytes_written  = r_bw;
  assign one_image_over = r_over;

endmodule

// File: tb/tb_tier2_stream_packer.sv
module tb_tier2_stream_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  we;
    logic [31:0] a;
  } exp4_t;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  we;
    logic [31:0] a;
  } exp8_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-byte instance
  logic        start4 = 1'b0;
  logic [19:0] tgt4 = '0;
  logic [15:0] din4 = '0;
  logic        two4 = 1'b0;
  logic        last4 = 1'b0;
  logic        vld4 = 1'b0;
  logic        rdy4;
  logic [31:0] dout4;
  logic [3:0]  we4;
  logic [31:0] addr4;
  logic [19:0] bw4;
  logic        over4;

  // 8-byte instance
  logic        start8 = 1'b0;
  logic [19:0] tgt8 = '0;
  logic [15:0] din8 = '0;
  logic        two8 = 1'b0;
  logic        last8 = 1'b0;
  logic        vld8 = 1'b0;
  logic        rdy8;
  logic [63:0] dout8;
  logic [7:0]  we8;
  logic [31:0] addr8;
  logic [19:0] bw8;
  logic        over8;

  exp4_t exp4_q[$];
  exp8_t exp8_q[$];
  exp4_t e4;
  exp8_t e8;

  tier2_stream_packer #(.OUT_BYTES(4), .ADDR_WIDTH(32), .BASE_ADDR(32'h0), .CNT_WIDTH(20)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .target_byte_number(tgt4),
    .in_data(din4), .in_two(two4), .in_last(last4), .in_valid(vld4), .in_ready(rdy4),
    .output_to_fpga(dout4), .write_en(we4), .output_address(addr4),
    .bytes_written(bw4), .one_image_over(over4)
  );

  tier2_stream_packer #(.OUT_BYTES(8), .ADDR_WIDTH(32), .BASE_ADDR(32'h100), .CNT_WIDTH(20)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .target_byte_number(tgt8),
    .in_data(din8), .in_two(two8), .in_last(last8), .in_valid(vld8), .in_ready(rdy8),
    .output_to_fpga(dout8), .write_en(we8), .output_address(addr8),
    .bytes_written(bw8), .one_image_over(over8)
  );

  // Scoreboard: every write cycle is popped against the expected queue.
  always @(negedge clk) begin
    if (we4 !== 4'h0) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL wr4_unexpected: got data=%h we=%h addr=%h, required no write", dout4, we4, addr4);
      end else begin
        e4 = exp4_q.pop_front();
        if (dout4 !== e4.d || we4 !== e4.we || addr4 !== e4.a) begin
          errors++;
          $display("FAIL wr4: got data=%h we=%h addr=%h, required data=%h we=%h addr=%h",
                   dout4, we4, addr4, e4.d, e4.we, e4.a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (we8 !== 8'h0) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL wr8_unexpected: got data=%h we=%h addr=%h, required no write", dout8, we8, addr8);
      end else begin
        e8 = exp8_q.pop_front();
        if (dout8 !== e8.d || we8 !== e8.we || addr8 !== e8.a) begin
          errors++;
          $display("FAIL wr8: got data=%h we=%h addr=%h, required data=%h we=%h addr=%h",
                   dout8, we8, addr8, e8.d, e8.we, e8.a);
        end
      end
    end
  end

  task automatic pulse_start4(input logic [19:0] tgt);
    @(posedge clk); #1;
    tgt4 = tgt; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic send4(input logic [15:0] d, input logic two, input logic last, output int waited);
    din4 = d; two4 = two; last4 = last; vld4 = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rdy4 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle4();
    vld4 = 1'b0; last4 = 1'b0; two4 = 1'b0; din4 = '0;
  endtask

  task automatic wait_over4(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (over4) seen = 1'b1;
    end
  endtask

  // Common end-of-image checks for the 4-byte instance, done inline per test.
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++; if (we4 !== 4'h0)     begin errors++; $display("FAIL reset_we4: got %h, required 0", we4); end
    checks++; if (dout4 !== 32'h0)  begin errors++; $display("FAIL reset_dout4: got %h, required 0", dout4); end
    checks++; if (addr4 !== 32'h0)  begin errors++; $display("FAIL reset_addr4: got %h, required 0", addr4); end
    checks++; if (bw4 !== 20'h0)    begin errors++; $display("FAIL reset_bw4: got %0d, required 0", bw4); end
    checks++; if (over4 !== 1'b0)   begin errors++; $display("FAIL reset_over4: got %b, required 0", over4); end
    checks++; if (rdy4 !== 1'b0)    begin errors++; $display("FAIL reset_rdy4: got %b, required 0", rdy4); end
    checks++; if (addr8 !== 32'h100) begin errors++; $display("FAIL reset_addr8: got %h, required 100", addr8); end
    checks++; if (we8 !== 8'h0)     begin errors++; $display("FAIL reset_we8: got %h, required 0", we8); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic finish_image4(input string name, input logic [19:0] exp_bw);
    bit seen;
    wait_over4(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_over: one_image_over not seen within 200 cycles", name); end
    checks++;
    if (bw4 !== exp_bw) begin errors++; $display("FAIL %s_bytes: got %0d, required %0d", name, bw4, exp_bw); end
    @(negedge clk);
    checks++;
    if (over4 !== 1'b0) begin errors++; $display("FAIL %s_pulse: over still %b, required 0", name, over4); end
    repeat (3) @(negedge clk);
    checks++;
    if (exp4_q.size() != 0) begin errors++; $display("FAIL %s_missing: %0d writes outstanding, required 0", name, exp4_q.size()); end
  endtask

  task automatic test_unlimited();
    int w;
    exp4_q.push_back('{d: 32'h01020304, we: 4'hF, a: 32'd0});
    exp4_q.push_back('{d: 32'h0506FFD9, we: 4'hF, a: 32'd1});
    pulse_start4(20'd0);
    send4(16'h0102, 1'b1, 1'b0, w);
    send4(16'h0304, 1'b1, 1'b0, w);
    send4(16'h0506, 1'b1, 1'b1, w);
    idle4();
    finish_image4("unlimited", 20'd8);
  endtask

  task automatic test_odd_align();
    int w;
    exp4_q.push_back('{d: 32'hAABBCCFF, we: 4'hF, a: 32'd0});
    exp4_q.push_back('{d: 32'hD9000000, we: 4'b1000, a: 32'd1});
    pulse_start4(20'd0);
    send4(16'hAA00, 1'b0, 1'b0, w);
    send4(16'hBBCC, 1'b1, 1'b1, w);
    idle4();
    finish_image4("odd_align", 20'd5);
  endtask

  task automatic test_truncation();
    int w;
    exp4_q.push_back('{d: 32'h01020304, we: 4'hF, a: 32'd0});
    exp4_q.push_back('{d: 32'hFFD90000, we: 4'b1100, a: 32'd1});
    pulse_start4(20'd6);
    for (int i = 0; i < 5; i++) begin
      send4({8'(2*i+1), 8'(2*i+2)}, 1'b1, (i == 4), w);
      checks++;
      if (w >= 100) begin errors++; $display("FAIL trunc_accept%0d: word not accepted within 100 cycles", i); end
    end
    idle4();
    finish_image4("truncation", 20'd6);
  endtask

  task automatic test_target_one();
    int w;
    exp4_q.push_back('{d: 32'hFFD90000, we: 4'b1100, a: 32'd0});
    pulse_start4(20'd1);
    send4(16'h1234, 1'b1, 1'b0, w);
    send4(16'h5678, 1'b1, 1'b1, w);
    checks++;
    if (w >= 100) begin errors++; $display("FAIL target1_drain: last word not accepted within 100 cycles"); end
    idle4();
    finish_image4("target1", 20'd2);
  endtask

  task automatic test_back_to_back();
    int w;
    bit seen;
    exp8_q.push_back('{d: 64'h0102030405060708, we: 8'hFF, a: 32'h100});
    exp8_q.push_back('{d: 64'h090A0B0C0D0E0F10, we: 8'hFF, a: 32'h101});
    exp8_q.push_back('{d: 64'h11121314FFD90000, we: 8'hFC, a: 32'h102});
    @(posedge clk); #1;
    tgt8 = 20'd0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din8 = {8'(2*i+1), 8'(2*i+2)}; two8 = 1'b1; last8 = (i == 9); vld8 = 1'b1;
      w = 0;
      @(negedge clk);
      while (!rdy8 && w < 100) begin w++; @(negedge clk); end
      checks++;
      if (w != 0) begin errors++; $display("FAIL b2b_ready%0d: in_ready low for %0d cycles, required 0", i, w); end
      @(posedge clk); #1;
    end
    vld8 = 1'b0; last8 = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (over8) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_over: one_image_over not seen within 200 cycles"); end
    checks++;
    if (bw8 !== 20'd22) begin errors++; $display("FAIL b2b_bytes: got %0d, required 22", bw8); end
    repeat (3) @(negedge clk);
    checks++;
    if (exp8_q.size() != 0) begin errors++; $display("FAIL b2b_missing: %0d writes outstanding, required 0", exp8_q.size()); end
  endtask

  task automatic test_rst_mid();
    int w;
    exp4_q.push_back('{d: 32'h11223344, we: 4'hF, a: 32'd0});
    pulse_start4(20'd0);
    send4(16'h1122, 1'b1, 1'b0, w);
    send4(16'h3344, 1'b1, 1'b0, w);
    send4(16'h5566, 1'b1, 1'b0, w);
    idle4();
    @(negedge clk);
    checks++;
    if (bw4 !== 20'd4) begin errors++; $display("FAIL rstmid_pre_bytes: got %0d, required 4", bw4); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (we4 !== 4'h0)    begin errors++; $display("FAIL rstmid_we: got %h, required 0", we4); end
    checks++; if (dout4 !== 32'h0) begin errors++; $display("FAIL rstmid_dout: got %h, required 0", dout4); end
    checks++; if (addr4 !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h, required 0", addr4); end
    checks++; if (bw4 !== 20'h0)   begin errors++; $display("FAIL rstmid_bytes: got %0d, required 0", bw4); end
    checks++; if (rdy4 !== 1'b0)   begin errors++; $display("FAIL rstmid_rdy: got %b, required 0", rdy4); end
    repeat (6) @(negedge clk);
    checks++; if (over4 !== 1'b0)  begin errors++; $display("FAIL rstmid_over: got %b, required 0", over4); end
    exp4_q.push_back('{d: 32'hA1A2FFD9, we: 4'hF, a: 32'd0});
    pulse_start4(20'd0);
    send4(16'hA1A2, 1'b1, 1'b1, w);
    idle4();
    finish_image4("rstmid_restart", 20'd4);
  endtask

  initial begin
    test_reset();
    test_unlimited();
    test_odd_align();
    test_truncation();
    test_target_one();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tier2_stream_packer.md
Name: tier2_stream_packer

Overview:
- Parametrised successor to the fixed 32-bit Tier-2 output stage.
- Accepts the Tier-2 codestream as 16-bit words carrying 1 or 2 valid bytes, and packs them big-endian into an OUT_BYTES-wide bus with per-byte write enables and a word address.
- Enforces a per-image byte budget, with truncation and drain of the remaining input, and appends the EOC marker 0xFFD9.
- Sits between codestream generation and the external FPGA/DDR writer.

Parameters:
OUT_BYTES, 4, output bus width in bytes; power of 2, at least 2.
ADDR_WIDTH, 32, output word-address width.
BASE_ADDR, 0, word address of the first output word of each image.
CNT_WIDTH, 20, width of the byte budget and byte counter.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins an image; sampled only in IDLE or DONE
target_byte_number  in  CNT_WIDTH  byte budget including EOC; latched at start; 0 = unlimited
in_data  in  16  codestream word; [15:8] is the first byte
in_two  in  1  1 = both bytes valid; 0 = only [15:8] valid
in_last  in  1  marks the final input word of the image
in_valid  in  1  input word valid
in_ready  out  1  input accepted when in_valid && in_ready
output_to_fpga  out  8*OUT_BYTES  packed word; lane k occupies bits [8*(OUT_BYTES-k)-1 -: 8]
write_en  out  OUT_BYTES  byte enables; bit j covers data bits [8j+7:8j]; nonzero only on a write cycle
output_address  out  ADDR_WIDTH  word address that goes with output_to_fpga
bytes_written  out  CNT_WIDTH  total bytes emitted for the current image, EOC included
one_image_over  out  1  1-cycle pulse on entry to DONE

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, ptr = 0, byte counter = 0, staging buffer = 0.
  - All outputs 0, except output_address = BASE_ADDR.
  - rst asserted mid-image abandons the image with no flush and no EOC.
- States: IDLE, PACK, EOC, FLUSH, DRAIN, DONE.
- IDLE/DONE:
  - in_ready = 0.
  - start latches the budget, clears the counter and ptr, sets the next address to BASE_ADDR, and moves to PACK.
- PACK:
  - in_ready = 1.
  - An accepted word contributes n bytes: n = 2 if in_two, else 1.
  - Allowed bytes a = min(n, target - 2 - count). With target = 0, a = n.
  - The a bytes go to lanes ptr, ptr+1 in order; ptr advances by a mod OUT_BYTES.
  - If a < n, the excess bytes are dropped (truncation).
  - Next state:
    - a < n, or count + a == target - 2 with target != 0: go to EOC. Remember whether in_last was already accepted.
    - in_last accepted without truncation: go to EOC.
- Word emission:
  - When lane OUT_BYTES-1 is filled, the full word is output on the next cycle with write_en all ones, at the current address.
  - The address then increments, wrapping modulo 2^ADDR_WIDTH.
  - A byte that overflows the word carries into lane 0 of the next word.
  - Sustained throughput: one input word per cycle, no bubbles.
  - The output side has no backpressure.
- EOC:
  - in_ready = 0.
  - Inserts 0xFF then 0xD9 through the same packing path in one cycle, then goes to FLUSH.
- FLUSH:
  - If ptr != 0, emits the partial word: write_en set for lanes 0..ptr-1 only, unfilled lanes = 0x00.
  - Goes to DRAIN if in_last has not been accepted, else to DONE.
- DRAIN:
  - in_ready = 1; words are accepted and discarded.
  - Accepting in_last moves to DONE.
- Budget edge cases:
  - target 1 or 2: zero data bytes, only EOC is written; bytes_written = 2.
  - target = 0 (unlimited): bytes_written = data bytes + 2.
- Counters:
  - bytes_written updates on the same cycle as the write_en it describes.
  - It saturates at 2^CNT_WIDTH - 1.
- start is ignored in PACK, EOC, FLUSH and DRAIN.
- in_valid while in_ready = 0 is held off; the word is not lost.

Test Plan:
- Unlimited budget, OUT_BYTES=4: 3 two-byte words 0x0102, 0x0304, 0x0506 with last on the third ->
  - word 0x01020304, we=4'hF, addr 0
  - word 0x0506FFD9, we=4'hF, addr 1
  - one_image_over pulses; bytes_written = 8
- Odd alignment: one-byte word 0xAA00, then 0xBBCC last -> word 0xAABBCCFF (we=F), then 0xD9000000 with we=4'b1000; bytes_written = 5.
- Truncation: target = 6, 5 two-byte words -> 4 data bytes plus FFD9; the remaining 3 words are drained with in_ready = 1; bytes_written = 6.
- target = 1: start, then 2 words -> single write 0xFFD90000 with we=4'b1100; both words drained.
- OUT_BYTES=8, BASE_ADDR=0x100: 10 full words streamed back-to-back with in_valid held high -> in_ready stays 1, 3 writes at 0x100–0x102, the last write partial.
- rst pulse mid-PACK -> all outputs 0 the next cycle, address = BASE_ADDR, no EOC written; a new start then runs cleanly.
